// File: rtl/spike_decoder.sv
// Spike-train decoder: rebuilds a sampled value from up/down crossing spikes and emits one snapshot per tick window.
// Latency: an event updates the accumulator on the next edge; a tick-cycle snapshot is visible on valid_o from the next cycle.
// Backpressure: valid/ready. A tick that arrives while an unaccepted sample is pending keeps the old sample and sets sticky overrun_o.
//
// Ports:
//   clk_i, rst_i             single clock, synchronous active-high reset
//   spike_up_i, spike_dn_i   spike levels from the encoder side; each 0->1 transition is one event
//   delta_i                  unsigned reconstruction step, applied on each counted event
//   recon_o                  reconstructed sample (snapshot of the accumulator)
//   up_cnt_o, dn_cnt_o       up/down events counted in the emitted window
//   valid_o, ready_i         sample handshake
//   overrun_o                sticky: a sample was dropped because the previous one was not accepted
module spike_decoder #(
   parameter int unsigned CLK_DIV      = 1200000,
   parameter logic [31:0] DEFAULT_BASE = 32'd40,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             spike_up_i,
   input  logic             spike_dn_i,
   input  logic [31:0]      delta_i,
   output logic [31:0]      recon_o,
   output logic [CNT_W-1:0] up_cnt_o,
   output logic [CNT_W-1:0] dn_cnt_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overrun_o
);

   localparam logic [31:0] TICK_LAST = 32'(CLK_DIV - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_VALID = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   // Edge detection
   logic             up_q;
   logic             dn_q;
   logic             armed;
   logic             up_ev;
   logic             dn_ev;

   // Reconstruction accumulator
   logic [31:0]      acc;
   logic [31:0]      acc_nxt;
   logic [32:0]      sum;

   // Tick generation
   logic [31:0]      tick_cnt;
   logic             tick;

   // Window counters
   logic [CNT_W-1:0] up_win;
   logic [CNT_W-1:0] dn_win;
   logic [CNT_W-1:0] up_win_inc;
   logic [CNT_W-1:0] dn_win_inc;

   // FSM actions
   logic             load;
   logic             set_ovr;

   // ------------------------------------------------------------------
   // Event detection. The edge registers clear on reset, so a level that
   // is already high when reset releases would otherwise look like a
   // fresh 0->1 transition. 'armed' suppresses events for the first
   // cycle after reset while the edge registers pick up the live levels.
   // ------------------------------------------------------------------
   always_comb begin
      up_ev = armed & spike_up_i & ~up_q;
      dn_ev = armed & spike_dn_i & ~dn_q;
   end

   // ------------------------------------------------------------------
   // Accumulator next value. Simultaneous up and down cancel out.
   // The 33-bit sum exposes the carry used for saturation at all-ones.
   // ------------------------------------------------------------------
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, delta_i};
      acc_nxt = acc;
      if (up_ev && !dn_ev) begin
         acc_nxt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      end else if (dn_ev && !up_ev) begin
         acc_nxt = (delta_i > acc) ? 32'd0 : (acc - delta_i);
      end
   end

   // ------------------------------------------------------------------
   // Window counters with saturation, and the tick strobe.
   // ------------------------------------------------------------------
   always_comb begin
      up_win_inc = (up_ev && (up_win != {CNT_W{1'b1}})) ? (up_win + CNT_W'(1)) : up_win;
      dn_win_inc = (dn_ev && (dn_win != {CNT_W{1'b1}})) ? (dn_win + CNT_W'(1)) : dn_win;
      tick       = (tick_cnt == TICK_LAST);
   end

   // ------------------------------------------------------------------
   // Output FSM: next state and snapshot/overrun actions.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      set_ovr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) begin
               load      = 1'b1;
               state_nxt = S_VALID;
            end
         end
         S_VALID: begin
            if (tick) begin
               // Accepting the current sample frees the slot for the new one
               // in the same cycle; otherwise the new window is lost.
               if (ready_i) begin
                  load = 1'b1;
               end else begin
                  set_ovr = 1'b1;
               end
            end else if (ready_i) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign valid_o = (state == S_VALID);

   // ------------------------------------------------------------------
   // FSM state register.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         up_q      <= 1'b0;
         dn_q      <= 1'b0;
         armed     <= 1'b0;
         acc       <= DEFAULT_BASE;
         tick_cnt  <= 32'd0;
         up_win    <= '0;
         dn_win    <= '0;
         recon_o   <= DEFAULT_BASE;
         up_cnt_o  <= '0;
         dn_cnt_o  <= '0;
         overrun_o <= 1'b0;
      end else begin
         up_q  <= spike_up_i;
         dn_q  <= spike_dn_i;
         armed <= 1'b1;
         acc   <= acc_nxt;

         if (tick) begin
            tick_cnt <= 32'd0;
            // An event in the tick cycle is reported in the closing window
            // and also opens the next one.
            up_win   <= CNT_W'(up_ev);
            dn_win   <= CNT_W'(dn_ev);
         end else begin
            tick_cnt <= tick_cnt + 32'd1;
            up_win   <= up_win_inc;
            dn_win   <= dn_win_inc;
         end

         // Snapshot carries this cycle's event, hence the *_nxt/*_inc values.
         if (load) begin
            recon_o  <= acc_nxt;
            up_cnt_o <= up_win_inc;
            dn_cnt_o <= dn_win_inc;
         end

         if (set_ovr) begin
            overrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_decoder.sv
module tb_spike_decoder;

   localparam int N = 2;

   logic        clk;
   logic        rst;
   logic        spike_up;
   logic        spike_dn;
   logic [31:0] delta;
   logic        ready;

   logic [31:0] r0, r1;
   logic [15:0] u0c, d0c;
   logic [1:0]  u1c, d1c;
   logic        v0, v1, ov0, ov1;

   // Instance 0: short window, wide counters. Instance 1: counters that saturate quickly.
   spike_decoder #(.CLK_DIV(4), .DEFAULT_BASE(32'd40), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .spike_up_i(spike_up), .spike_dn_i(spike_dn),
      .delta_i(delta), .recon_o(r0), .up_cnt_o(u0c), .dn_cnt_o(d0c),
      .valid_o(v0), .ready_i(ready), .overrun_o(ov0));

   spike_decoder #(.CLK_DIV(8), .DEFAULT_BASE(32'd1000), .CNT_W(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .spike_up_i(spike_up), .spike_dn_i(spike_dn),
      .delta_i(delta), .recon_o(r1), .up_cnt_o(u1c), .dn_cnt_o(d1c),
      .valid_o(v1), .ready_i(ready), .overrun_o(ov1));

   logic [31:0] o_recon [N];
   logic [15:0] o_up    [N];
   logic [15:0] o_dn    [N];
   logic        o_valid [N];
   logic        o_ovr   [N];

   assign o_recon[0] = r0;
   assign o_recon[1] = r1;
   assign o_up[0]    = u0c;
   assign o_up[1]    = {14'd0, u1c};
   assign o_dn[0]    = d0c;
   assign o_dn[1]    = {14'd0, d1c};
   assign o_valid[0] = v0;
   assign o_valid[1] = v1;
   assign o_ovr[0]   = ov0;
   assign o_ovr[1]   = ov1;

   int errors = 0;
   int checks = 0;

   // Expected values for directed checkpoints (instance 0)
   logic        e_valid;
   logic [31:0] e_recon;
   logic [15:0] e_up, e_dn;
   logic        e_ovr;
   bit          chk;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: one window of plain integer bookkeeping per instance.
   // ------------------------------------------------------------------
   int     mdiv  [N] = '{4, 8};
   longint mbase [N] = '{40, 1000};
   int     mcmax [N] = '{65535, 3};
   longint macc  [N];
   int     mphase[N];
   int     mwu   [N], mwd [N];
   bit     mpu   [N], mpd [N], marm [N];
   bit     mvalid[N], movr[N];
   longint mrecon[N];
   int     mup   [N], mdn [N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            macc[i] = mbase[i]; mphase[i] = 0; mwu[i] = 0; mwd[i] = 0;
            mpu[i] = 0; mpd[i] = 0; marm[i] = 0;
            mvalid[i] = 0; movr[i] = 0; mrecon[i] = mbase[i]; mup[i] = 0; mdn[i] = 0;
         end else begin
            bit eu, ed, tk;
            longint d;
            d  = delta;
            eu = marm[i] && spike_up && !mpu[i];
            ed = marm[i] && spike_dn && !mpd[i];
            mpu[i] = spike_up; mpd[i] = spike_dn; marm[i] = 1;
            if (eu && !ed) macc[i] = (macc[i] + d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : macc[i] + d;
            else if (ed && !eu) macc[i] = (macc[i] < d) ? 0 : macc[i] - d;
            if (eu && mwu[i] < mcmax[i]) mwu[i]++;
            if (ed && mwd[i] < mcmax[i]) mwd[i]++;
            tk = (mphase[i] == mdiv[i] - 1);
            mphase[i] = tk ? 0 : mphase[i] + 1;
            if (tk) begin
               if (!mvalid[i] || ready) begin
                  mvalid[i] = 1; mrecon[i] = macc[i]; mup[i] = mwu[i]; mdn[i] = mwd[i];
               end else begin
                  movr[i] = 1;
               end
               mwu[i] = eu ? 1 : 0;
               mwd[i] = ed ? 1 : 0;
            end else if (mvalid[i] && ready) begin
               mvalid[i] = 0;
            end
         end
      end
   end

   // One clock edge; outputs are then sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      spike_up = 0; spike_dn = 0; ready = 0; delta = 0;
      do_reset();
      checks++; if (v0 !== 1'b0)      begin errors++; $display("FAIL reset valid got %0b exp 0", v0); end
      checks++; if (r0 !== 32'd40)    begin errors++; $display("FAIL reset recon got %0d exp 40", r0); end
      checks++; if (u0c !== 16'd0)    begin errors++; $display("FAIL reset up_cnt got %0d exp 0", u0c); end
      checks++; if (d0c !== 16'd0)    begin errors++; $display("FAIL reset dn_cnt got %0d exp 0", d0c); end
      checks++; if (ov0 !== 1'b0)     begin errors++; $display("FAIL reset overrun got %0b exp 0", ov0); end
      checks++; if (r1 !== 32'd1000)  begin errors++; $display("FAIL reset recon1 got %0d exp 1000", r1); end
   endtask

   task automatic test_up_pulses();
      logic [8:0] pat;
      pat = 9'b010101000;
      spike_dn = 0; delta = 5; ready = 1;
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         spike_up = pat[c];
         step();
         chk = 1; e_dn = 0; e_ovr = 0;
         case (c)
            3: begin e_valid = 1; e_recon = 45; e_up = 1; end
            4: begin e_valid = 0; e_recon = 45; e_up = 1; end
            7: begin e_valid = 1; e_recon = 55; e_up = 3; end
            8: begin e_valid = 0; e_recon = 55; e_up = 3; end
            default: chk = 0;
         endcase
         if (chk) begin
            checks++; if (v0 !== e_valid)  begin errors++; $display("FAIL up_pulses c=%0d valid got %0b exp %0b", c, v0, e_valid); end
            checks++; if (r0 !== e_recon)  begin errors++; $display("FAIL up_pulses c=%0d recon got %0d exp %0d", c, r0, e_recon); end
            checks++; if (u0c !== e_up)    begin errors++; $display("FAIL up_pulses c=%0d up_cnt got %0d exp %0d", c, u0c, e_up); end
            checks++; if (d0c !== e_dn)    begin errors++; $display("FAIL up_pulses c=%0d dn_cnt got %0d exp %0d", c, d0c, e_dn); end
            checks++; if (ov0 !== e_ovr)   begin errors++; $display("FAIL up_pulses c=%0d overrun got %0b exp %0b", c, ov0, e_ovr); end
         end
      end
   endtask

   task automatic test_down_saturate();
      spike_up = 0; spike_dn = 0; delta = 30; ready = 1;
      do_reset();
      for (int c = 0; c <= 7; c++) begin
         spike_dn = (c == 3 || c == 5);
         step();
         chk = 1; e_valid = 1; e_up = 0; e_ovr = 0;
         case (c)
            3: begin e_recon = 10; e_dn = 1; end
            7: begin e_recon = 0;  e_dn = 2; end
            default: chk = 0;
         endcase
         if (chk) begin
            checks++; if (v0 !== e_valid)  begin errors++; $display("FAIL down_sat c=%0d valid got %0b exp %0b", c, v0, e_valid); end
            checks++; if (r0 !== e_recon)  begin errors++; $display("FAIL down_sat c=%0d recon got %0d exp %0d", c, r0, e_recon); end
            checks++; if (u0c !== e_up)    begin errors++; $display("FAIL down_sat c=%0d up_cnt got %0d exp %0d", c, u0c, e_up); end
            checks++; if (d0c !== e_dn)    begin errors++; $display("FAIL down_sat c=%0d dn_cnt got %0d exp %0d", c, d0c, e_dn); end
         end
      end
   endtask

   // Level held through reset release must not count; a later 10-cycle level counts once.
   task automatic test_held_level();
      spike_up = 1; spike_dn = 0; delta = 7; ready = 1;
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         spike_up = (c <= 3) || (c >= 5 && c <= 14);
         step();
         chk = 1; e_valid = 1; e_dn = 0;
         case (c)
            3:  begin e_recon = 40; e_up = 0; end
            7:  begin e_recon = 47; e_up = 1; end
            11: begin e_recon = 47; e_up = 0; end
            15: begin e_recon = 47; e_up = 0; end
            default: chk = 0;
         endcase
         if (chk) begin
            checks++; if (v0 !== e_valid)  begin errors++; $display("FAIL held_level c=%0d valid got %0b exp %0b", c, v0, e_valid); end
            checks++; if (r0 !== e_recon)  begin errors++; $display("FAIL held_level c=%0d recon got %0d exp %0d", c, r0, e_recon); end
            checks++; if (u0c !== e_up)    begin errors++; $display("FAIL held_level c=%0d up_cnt got %0d exp %0d", c, u0c, e_up); end
         end
      end
   endtask

   task automatic test_simultaneous();
      spike_up = 0; spike_dn = 0; delta = 9; ready = 1;
      do_reset();
      for (int c = 0; c <= 3; c++) begin
         spike_up = (c == 2);
         spike_dn = (c == 2);
         step();
      end
      checks++; if (r0 !== 32'd40) begin errors++; $display("FAIL simultaneous recon got %0d exp 40", r0); end
      checks++; if (u0c !== 16'd1) begin errors++; $display("FAIL simultaneous up_cnt got %0d exp 1", u0c); end
      checks++; if (d0c !== 16'd1) begin errors++; $display("FAIL simultaneous dn_cnt got %0d exp 1", d0c); end
      checks++; if (v0 !== 1'b1)   begin errors++; $display("FAIL simultaneous valid got %0b exp 1", v0); end
   endtask

   task automatic test_overrun();
      spike_up = 0; spike_dn = 0; delta = 3; ready = 0;
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         spike_up = (c == 5);
         ready    = (c >= 8);
         step();
         chk = 1; e_up = 0;
         case (c)
            3:  begin e_valid = 1; e_recon = 40; e_ovr = 0; end
            7:  begin e_valid = 1; e_recon = 40; e_ovr = 1; end
            8:  begin e_valid = 0; e_recon = 40; e_ovr = 1; end
            11: begin e_valid = 1; e_recon = 43; e_ovr = 1; end
            default: chk = 0;
         endcase
         if (chk) begin
            checks++; if (v0 !== e_valid)  begin errors++; $display("FAIL overrun c=%0d valid got %0b exp %0b", c, v0, e_valid); end
            checks++; if (r0 !== e_recon)  begin errors++; $display("FAIL overrun c=%0d recon got %0d exp %0d", c, r0, e_recon); end
            checks++; if (u0c !== e_up)    begin errors++; $display("FAIL overrun c=%0d up_cnt got %0d exp %0d", c, u0c, e_up); end
            checks++; if (ov0 !== e_ovr)   begin errors++; $display("FAIL overrun c=%0d overrun got %0b exp %0b", c, ov0, e_ovr); end
         end
      end
   endtask

   task automatic test_back_to_back();
      spike_up = 0; spike_dn = 0; delta = 4; ready = 0;
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         spike_up = (c == 5);
         ready    = (c == 7);
         step();
      end
      checks++; if (v0 !== 1'b1)   begin errors++; $display("FAIL back_to_back valid got %0b exp 1", v0); end
      checks++; if (r0 !== 32'd44) begin errors++; $display("FAIL back_to_back recon got %0d exp 44", r0); end
      checks++; if (u0c !== 16'd1) begin errors++; $display("FAIL back_to_back up_cnt got %0d exp 1", u0c); end
      checks++; if (ov0 !== 1'b0)  begin errors++; $display("FAIL back_to_back overrun got %0b exp 0", ov0); end
   endtask

   task automatic test_reset_mid();
      spike_up = 0; spike_dn = 0; delta = 6; ready = 0;
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         spike_up = (c == 1);
         step();
      end
      checks++; if (r0 !== 32'd46) begin errors++; $display("FAIL reset_mid pre recon got %0d exp 46", r0); end
      checks++; if (ov0 !== 1'b1)  begin errors++; $display("FAIL reset_mid pre overrun got %0b exp 1", ov0); end
      do_reset();
      checks++; if (v0 !== 1'b0)   begin errors++; $display("FAIL reset_mid valid got %0b exp 0", v0); end
      checks++; if (r0 !== 32'd40) begin errors++; $display("FAIL reset_mid recon got %0d exp 40", r0); end
      checks++; if (u0c !== 16'd0) begin errors++; $display("FAIL reset_mid up_cnt got %0d exp 0", u0c); end
      checks++; if (ov0 !== 1'b0)  begin errors++; $display("FAIL reset_mid overrun got %0b exp 0", ov0); end
      ready = 1;
      for (int c = 0; c <= 3; c++) begin
         step();
         if (c == 2) begin
            checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_mid tick_restart c=2 valid got %0b exp 0", v0); end
         end
         if (c == 3) begin
            checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL reset_mid tick_restart c=3 valid got %0b exp 1", v0); end
         end
      end
   endtask

   task automatic test_random();
      int sel;
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 199) == 0);
         spike_up = $urandom_range(0, 1) == 1;
         spike_dn = $urandom_range(0, 1) == 1;
         ready    = $urandom_range(0, 3) != 0;
         sel      = $urandom_range(0, 7);
         if (sel == 0)      delta = 32'd0;
         else if (sel == 1) delta = 32'hF000_0000 | 32'($urandom_range(0, 65535));
         else               delta = 32'($urandom_range(1, 200));
         step();
         for (int i = 0; i < N; i++) begin
            checks++; if (o_valid[i] !== mvalid[i])        begin errors++; $display("FAIL random n=%0d inst%0d valid got %0b exp %0b", n, i, o_valid[i], mvalid[i]); end
            checks++; if (o_recon[i] !== 32'(mrecon[i]))   begin errors++; $display("FAIL random n=%0d inst%0d recon got %0d exp %0d", n, i, o_recon[i], mrecon[i]); end
            checks++; if (o_up[i] !== 16'(mup[i]))         begin errors++; $display("FAIL random n=%0d inst%0d up_cnt got %0d exp %0d", n, i, o_up[i], mup[i]); end
            checks++; if (o_dn[i] !== 16'(mdn[i]))         begin errors++; $display("FAIL random n=%0d inst%0d dn_cnt got %0d exp %0d", n, i, o_dn[i], mdn[i]); end
            checks++; if (o_ovr[i] !== movr[i])            begin errors++; $display("FAIL random n=%0d inst%0d overrun got %0b exp %0b", n, i, o_ovr[i], movr[i]); end
         end
      end
      rst = 0;
   endtask

   initial begin
      rst = 1; spike_up = 0; spike_dn = 0; delta = 0; ready = 0;
      step();
      step();
      test_reset();
      test_up_pulses();
      test_down_saturate();
      test_held_level();
      test_simultaneous();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter CLK_DIV, default 1200000: number of clk_i cycles between sample ticks; legal range 1..2^32-1.
REQ-002 Parameter DEFAULT_BASE, default 40: reset value of the reconstruction accumulator, unsigned 32-bit.
REQ-003 Parameter CNT_W, default 16: width of the per-window spike event counters.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 spike_up_i  input  1  up-crossing spike level from the encoder side.
REQ-007 spike_dn_i  input  1  down-crossing spike level from the encoder side.
REQ-008 delta_i  input  32  unsigned reconstruction step, sampled on each counted event.
REQ-009 recon_o  output  32  reconstructed sample, held stable while valid_o is high.
REQ-010 up_cnt_o  output  CNT_W  up events counted in the emitted window.
REQ-011 dn_cnt_o  output  CNT_W  down events counted in the emitted window.
REQ-012 valid_o  output  1  sample-available flag of the valid/ready handshake.
REQ-013 ready_i  input  1  downstream accepts the sample when valid_o & ready_i.
REQ-014 overrun_o  output  1  sticky flag: a sample was dropped.

Function
REQ-015 Each spike input SHALL be rising-edge detected against a registered copy; only a 0->1 transition is one event; a held-high level SHALL count once.
REQ-016 The cycle after an up event alone, accumulator SHALL become acc + delta_i, saturating at 0xFFFFFFFF.
REQ-017 The cycle after a down event alone, accumulator SHALL become acc - delta_i, saturating at 0.
REQ-018 Up and down events in the same cycle SHALL leave the accumulator unchanged but SHALL increment both window counters.
REQ-019 Window counters SHALL increment by one per event and saturate at 2^CNT_W-1.
REQ-020 A tick counter SHALL count 0..CLK_DIV-1 and wrap; the tick SHALL assert for one cycle when the count equals CLK_DIV-1.
REQ-021 On a tick, the snapshot registers SHALL capture the accumulator value including any event applied in that same cycle, and both window counters including any event in that cycle; window counters SHALL then restart at 0, or at 1 for a channel with an event in the tick cycle.
REQ-022 FSM states: S_IDLE (valid_o=0) and S_VALID (valid_o=1).
REQ-023 S_IDLE + tick -> load snapshot, go S_VALID; valid_o high from the next cycle.
REQ-024 S_VALID + ready_i without tick -> go S_IDLE the next cycle.
REQ-025 S_VALID + tick + ready_i in the same cycle -> load new snapshot, remain S_VALID (back-to-back, no lost sample).
REQ-026 S_VALID + tick + !ready_i -> keep old snapshot (outputs stable), set overrun_o, discard new window counts.
REQ-027 recon_o, up_cnt_o and dn_cnt_o SHALL change only on a snapshot load.
REQ-028 overrun_o SHALL stay high until reset.
REQ-029 delta_i = 0 SHALL count events without changing the accumulator.

Reset
REQ-030 While rst_i is high at a clock edge: accumulator = DEFAULT_BASE, tick counter = 0, window counters = 0, edge registers = 0, FSM = S_IDLE.
REQ-031 Reset values of outputs: valid_o = 0, recon_o = DEFAULT_BASE, up_cnt_o = 0, dn_cnt_o = 0, overrun_o = 0.
REQ-032 Reset asserted mid-handshake SHALL drop the pending sample with no overrun indication; a spike held high through reset release SHALL NOT count as an event.

Verification
REQ-033 CLK_DIV=4, delta=5, three separate up pulses in one window, ready_i=1 -> recon_o=55, up_cnt_o=3, dn_cnt_o=0, valid_o high for 1 cycle.
REQ-034 DEFAULT_BASE=40, delta=30, two down pulses -> accumulator 10 then 0 (saturated), never wraps.
REQ-035 spike_up_i held high for 10 cycles -> exactly one event, recon_o = base + delta.
REQ-036 Simultaneous up and down edges -> recon_o unchanged, up_cnt_o=1, dn_cnt_o=1.
REQ-037 ready_i=0 across two ticks -> first snapshot held, overrun_o=1; ready_i=1 -> valid_o drops next cycle, overrun_o stays 1.
REQ-038 rst_i pulsed while valid_o=1 -> all outputs at reset values the next cycle; tick period restarts from 0.
